// File: rtl/control_filtro_biquad_pkg.sv
// -----------------------------------------------------------------------------
// control_filtro_biquad_pkg
// Shared constants for the biquad control unit and its datapath:
//   - FSM state encodings (3 bits), IDLE, five MAC steps, SHIFT
//   - mux select codes for the signal (S), coefficient (C) and addend (Z)
//     operands of the datapath operation resultado = S*C + Z
//   - dwell counter width
// -----------------------------------------------------------------------------
package control_filtro_biquad_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MAC1  = 3'd1;
  localparam logic [2:0] ST_MAC2  = 3'd2;
  localparam logic [2:0] ST_MAC3  = 3'd3;
  localparam logic [2:0] ST_MAC4  = 3'd4;
  localparam logic [2:0] ST_MAC5  = 3'd5;
  localparam logic [2:0] ST_SHIFT = 3'd6;

  localparam logic [2:0] SEL_S_FK  = 3'd0;
  localparam logic [2:0] SEL_S_FK1 = 3'd1;
  localparam logic [2:0] SEL_S_FK2 = 3'd2;
  localparam logic [2:0] SEL_S_UK  = 3'd3;

  // b2 equals b0 for the symmetric low-pass numerator, so SEL_C_B0 serves both
  localparam logic [1:0] SEL_C_A1 = 2'd0;
  localparam logic [1:0] SEL_C_A2 = 2'd1;
  localparam logic [1:0] SEL_C_B0 = 2'd2;
  localparam logic [1:0] SEL_C_B1 = 2'd3;

  localparam logic [2:0] SEL_Z_CERO = 3'd0;
  localparam logic [2:0] SEL_Z_UK   = 3'd1;
  localparam logic [2:0] SEL_Z_AC1  = 3'd2;
  localparam logic [2:0] SEL_Z_AC2  = 3'd3;
  localparam logic [2:0] SEL_Z_AC3  = 3'd4;

  localparam int CNT_W = 4;

endpackage

// File: rtl/control_filtro_biquad_contador_espera.sv
// -----------------------------------------------------------------------------
// contador_espera
// Dwell counter for the MAC states. Counts cycles spent in the current state
// and flags the last dwell cycle.
//   i_clk    system clock
//   i_reset  synchronous active-high reset (count -> 0)
//   i_clr    reload the count to 0 at the next edge (state change / idle)
//   o_fin    high during the last of MAC_CYCLES dwell cycles
// -----------------------------------------------------------------------------
module contador_espera
  import control_filtro_biquad_pkg::*;
#(
  parameter int MAC_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_fin
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAC_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at LAST so the count can never wrap while a state is held
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_fin = (r_cnt == LAST);

endmodule

// File: rtl/control_filtro_biquad.sv
// -----------------------------------------------------------------------------
// control_filtro_biquad
// Sequencer for the low-pass biquad datapath. Each start strobe runs five
// multiply-accumulate steps and one history shift, then pulses done.
//   clk       system clock
//   reset     synchronous active-high reset
//   start     one-cycle sample strobe (ignored while busy, sets overrun)
//   en1..en7  datapath register loads: yk, fk, fk1, fk2, acum1, acum2, acum3
//   selmuxS   signal operand select
//   selmuxC   coefficient select
//   selmuxZ   addend select
//   busy      sequence in progress (MAC1..SHIFT)
//   done      one-cycle pulse in the first IDLE cycle after SHIFT
//   overrun   sticky: start seen while busy, cleared only by reset
// All outputs are decoded from registers only; none depends on start.
// -----------------------------------------------------------------------------
module control_filtro_biquad
  import control_filtro_biquad_pkg::*;
#(
  parameter int MAC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [1:0] selmuxC,
  output logic [2:0] selmuxZ,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_done;
  logic       r_overrun;
  logic       w_fin;
  logic       w_clr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_MAC1;
      ST_MAC1:  if (w_fin) w_next = ST_MAC2;
      ST_MAC2:  if (w_fin) w_next = ST_MAC3;
      ST_MAC3:  if (w_fin) w_next = ST_MAC4;
      ST_MAC4:  if (w_fin) w_next = ST_MAC5;
      ST_MAC5:  if (w_fin) w_next = ST_SHIFT;
      ST_SHIFT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Counter restarts from 0 in the first cycle of every new state and is
  // parked at 0 while idle
  assign w_clr = (w_next != r_state) || (r_state == ST_IDLE);

  contador_espera #(
    .MAC_CYCLES(MAC_CYCLES)
  ) u_espera (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_clr),
    .o_fin   (w_fin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered so done lands in the IDLE cycle that follows SHIFT
      r_done  <= (r_state == ST_SHIFT);
      if (start && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Selects are held for the whole dwell; each load enable fires only in the
  // last dwell cycle so the arithmetic has settled when it is captured
  always_comb begin
    en1     = 1'b0;
    en2     = 1'b0;
    en3     = 1'b0;
    en4     = 1'b0;
    en5     = 1'b0;
    en6     = 1'b0;
    en7     = 1'b0;
    selmuxS = SEL_S_FK;
    selmuxC = SEL_C_A1;
    selmuxZ = SEL_Z_CERO;
    case (r_state)
      ST_MAC1: begin
        selmuxS = SEL_S_FK1;
        selmuxC = SEL_C_A1;
        selmuxZ = SEL_Z_UK;
        en5     = w_fin;
      end
      ST_MAC2: begin
        selmuxS = SEL_S_FK2;
        selmuxC = SEL_C_A2;
        selmuxZ = SEL_Z_AC1;
        en2     = w_fin;
      end
      ST_MAC3: begin
        selmuxS = SEL_S_FK;
        selmuxC = SEL_C_B0;
        selmuxZ = SEL_Z_CERO;
        en6     = w_fin;
      end
      ST_MAC4: begin
        selmuxS = SEL_S_FK1;
        selmuxC = SEL_C_B1;
        selmuxZ = SEL_Z_AC2;
        en7     = w_fin;
      end
      ST_MAC5: begin
        selmuxS = SEL_S_FK2;
        selmuxC = SEL_C_B0;
        selmuxZ = SEL_Z_AC3;
        en1     = w_fin;
      end
      // fk1 <= fk and fk2 <= fk1 on the same edge: both registers sample
      // their pre-edge inputs, so the history shifts correctly
      ST_SHIFT: begin
        en3 = 1'b1;
        en4 = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_control_filtro_biquad.sv
// -----------------------------------------------------------------------------
// tb_control_filtro_biquad
// Directed bench for the biquad sequencer. Two instances: u1 (MAC_CYCLES=1)
// drives a small Q2.14 behavioural datapath, u3 (MAC_CYCLES=3) checks dwell.
// Observed outputs are packed as
//   {en7,en6,en5,en4,en3,en2,en1, selmuxS, selmuxC, selmuxZ, busy, done}
// -----------------------------------------------------------------------------
module tb_control_filtro_biquad;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;

  always #5 clk = ~clk;

  logic       e1_1, e2_1, e3_1, e4_1, e5_1, e6_1, e7_1, busy1, done1, ov1;
  logic [2:0] s1, z1;
  logic [1:0] c1;
  logic       e1_3, e2_3, e3_3, e4_3, e5_3, e6_3, e7_3, busy3, done3, ov3;
  logic [2:0] s3, z3;
  logic [1:0] c3;

  control_filtro_biquad #(.MAC_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .en1(e1_1), .en2(e2_1), .en3(e3_1), .en4(e4_1), .en5(e5_1), .en6(e6_1), .en7(e7_1),
    .selmuxS(s1), .selmuxC(c1), .selmuxZ(z1),
    .busy(busy1), .done(done1), .overrun(ov1)
  );

  control_filtro_biquad #(.MAC_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .start(start3),
    .en1(e1_3), .en2(e2_3), .en3(e3_3), .en4(e4_3), .en5(e5_3), .en6(e6_3), .en7(e7_3),
    .selmuxS(s3), .selmuxC(c3), .selmuxZ(z3),
    .busy(busy3), .done(done3), .overrun(ov3)
  );

  logic [16:0] obs1, obs3;
  assign obs1 = {e7_1, e6_1, e5_1, e4_1, e3_1, e2_1, e1_1, s1, c1, z1, busy1, done1};
  assign obs3 = {e7_3, e6_3, e5_3, e4_3, e3_3, e2_3, e1_3, s3, c3, z3, busy3, done3};

  // Expected MAC_CYCLES=1 trace, cycle 0 = start cycle
  logic [16:0] seq1 [0:8] = '{
    17'b0000000_000_00_000_0_0,
    17'b0010000_001_00_001_1_0,
    17'b0000010_010_01_010_1_0,
    17'b0100000_000_10_000_1_0,
    17'b1000000_001_11_011_1_0,
    17'b0000001_010_10_100_1_0,
    17'b0001100_000_00_000_1_0,
    17'b0000000_000_00_000_0_1,
    17'b0000000_000_00_000_0_0
  };

  // Per-MAC-state {S,C,Z} and enable mask {en7..en1}
  logic [7:0] mac_sel [0:4] = '{
    {3'd1, 2'd0, 3'd1}, {3'd2, 2'd1, 3'd2}, {3'd0, 2'd2, 3'd0},
    {3'd1, 2'd3, 3'd3}, {3'd2, 2'd2, 3'd4}
  };
  logic [6:0] mac_en [0:4] = '{
    7'b0010000, 7'b0000010, 7'b0100000, 7'b1000000, 7'b0000001
  };

  // Behavioural Q2.14 datapath driven by u1
  logic signed [15:0] uk = 16'sd0;
  logic signed [15:0] fk = 16'sd0, fk1 = 16'sd0, fk2 = 16'sd0;
  logic signed [15:0] ac1 = 16'sd0, ac2 = 16'sd0, ac3 = 16'sd0, yk = 16'sd0;
  logic signed [15:0] ca1n = 16'sd0, ca2n = 16'sd0, cb0 = 16'sd0, cb1 = 16'sd16384;
  logic signed [15:0] opS, opC, opZ, res;
  logic signed [31:0] prod;

  always_comb begin
    opS = 16'sd0;
    opC = 16'sd0;
    opZ = 16'sd0;
    case (s1)
      3'd0: opS = fk;
      3'd1: opS = fk1;
      3'd2: opS = fk2;
      3'd3: opS = uk;
      default: opS = 16'sd0;
    endcase
    case (c1)
      2'd0: opC = ca1n;
      2'd1: opC = ca2n;
      2'd2: opC = cb0;
      default: opC = cb1;
    endcase
    case (z1)
      3'd1: opZ = uk;
      3'd2: opZ = ac1;
      3'd3: opZ = ac2;
      3'd4: opZ = ac3;
      default: opZ = 16'sd0;
    endcase
    prod = opS * opC;
    res  = opZ + prod[29:14];
  end

  always @(posedge clk) begin
    if (e1_1) yk  <= res;
    if (e2_1) fk  <= res;
    if (e3_1) fk1 <= fk;
    if (e4_1) fk2 <= fk1;
    if (e5_1) ac1 <= res;
    if (e6_1) ac2 <= res;
    if (e7_1) ac3 <= res;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_total++;
      if ({obs1, ov1} !== 18'd0) $display("FAIL reset_u1 c=%0d got=%h exp=0", c, {obs1, ov1});
      else n_pass++;
      n_total++;
      if ({obs3, ov3} !== 18'd0) $display("FAIL reset_u3 c=%0d got=%h exp=0", c, {obs3, ov3});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_sequence_mc1();
    for (int c = 0; c <= 8; c++) begin
      start1 = (c == 0);
      n_total++;
      if (obs1 !== seq1[c]) $display("FAIL seq_mc1 c=%0d got=%b exp=%b", c, obs1, seq1[c]);
      else n_pass++;
      tick();
    end
    start1 = 1'b0;
  endtask

  task automatic test_datapath_impulse();
    logic signed [15:0] ukv [0:3];
    logic signed [15:0] yexp [0:3];
    bit got;
    ukv  = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0};
    yexp = '{16'sd0, 16'sd16384, 16'sd0, 16'sd0};
    for (int i = 0; i < 4; i++) begin
      uk = ukv[i];
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (done1) got = 1'b1;
        else tick();
      end
      n_total++;
      if (!got) $display("FAIL dp_done sample=%0d got=no_done exp=done", i);
      else n_pass++;
      n_total++;
      if (yk !== yexp[i]) $display("FAIL dp_yk sample=%0d got=%0d exp=%0d", i, yk, yexp[i]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_dwell_mc3();
    logic [16:0] exp_v;
    for (int c = 0; c <= 18; c++) begin
      start3 = (c == 0);
      if (c >= 1 && c <= 15)
        exp_v = {((c - 1) % 3 == 2) ? mac_en[(c - 1) / 3] : 7'b0, mac_sel[(c - 1) / 3], 1'b1, 1'b0};
      else if (c == 16)
        exp_v = 17'b0001100_000_00_000_1_0;
      else if (c == 17)
        exp_v = 17'b0000000_000_00_000_0_1;
      else
        exp_v = 17'd0;
      n_total++;
      if (obs3 !== exp_v) $display("FAIL dwell_mc3 c=%0d got=%b exp=%b", c, obs3, exp_v);
      else n_pass++;
      tick();
    end
    start3 = 1'b0;
  endtask

  task automatic test_overrun_back_to_back();
    logic [16:0] exp_v;
    for (int c = 0; c <= 15; c++) begin
      start1 = (c == 0) || (c == 3) || (c == 7);
      exp_v = (c <= 7) ? seq1[c] : seq1[c - 7];
      n_total++;
      if (obs1 !== exp_v) $display("FAIL b2b_seq c=%0d got=%b exp=%b", c, obs1, exp_v);
      else n_pass++;
      n_total++;
      if (ov1 !== (c >= 4)) $display("FAIL overrun c=%0d got=%b exp=%b", c, ov1, (c >= 4));
      else n_pass++;
      tick();
    end
    start1 = 1'b0;
  endtask

  task automatic test_reset_midseq();
    for (int c = 0; c <= 7; c++) begin
      start1 = (c == 0);
      reset  = (c == 3);
      n_total++;
      if (c <= 3) begin
        if (obs1 !== seq1[c]) $display("FAIL rst_mid c=%0d got=%b exp=%b", c, obs1, seq1[c]);
        else n_pass++;
      end else begin
        if ({obs1, ov1} !== 18'd0) $display("FAIL rst_mid c=%0d got=%b exp=0", c, {obs1, ov1});
        else n_pass++;
      end
      tick();
    end
    // reset and start together: reset wins
    reset = 1'b1;
    start1 = 1'b1;
    tick();
    reset = 1'b0;
    start1 = 1'b0;
    n_total++;
    if ({obs1, ov1} !== 18'd0) $display("FAIL rst_and_start got=%b exp=0", {obs1, ov1});
    else n_pass++;
    tick();
    for (int c = 0; c <= 8; c++) begin
      start1 = (c == 0);
      n_total++;
      if (obs1 !== seq1[c]) $display("FAIL clean_seq c=%0d got=%b exp=%b", c, obs1, seq1[c]);
      else n_pass++;
      tick();
    end
    start1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence_mc1();
    test_datapath_impulse();
    test_dwell_mc3();
    tick();
    test_overrun_back_to_back();
    test_reset_midseq();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
